// File: rtl/pygmy_uart_gpio_system.sv
// UART-to-GPIO bridge: each valid 8N1 byte received on i_UART_TXD is latched onto o_GPIO_7..0.
// Optional echo transmitter on o_UART_RXD is enabled by defining UART_ECHO_EN.
module pygmy_uart_gpio_system #(
  parameter int unsigned CLKS_PER_BIT = 1250
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic i_UART_TXD,
  output logic o_UART_RXD,
  output logic o_GPIO_0,
  output logic o_GPIO_1,
  output logic o_GPIO_2,
  output logic o_GPIO_3,
  output logic o_GPIO_4,
  output logic o_GPIO_5,
  output logic o_GPIO_6,
  output logic o_GPIO_7
);

  localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 32'd1);
  localparam logic [15:0] HALF_M1 = 16'((CLKS_PER_BIT / 32'd2) - 32'd1);

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_t;

  logic [1:0]  rst_sync_r;
  logic        rst_n_s;
  logic        rx_meta_r;
  logic        rx_sync_r;
  logic        rx_prev_r;
  rx_state_t   rx_state_r, rx_state_nxt_s;
  logic [15:0] rx_cnt_r, rx_cnt_nxt_s;
  logic [2:0]  rx_bit_r, rx_bit_nxt_s;
  logic [7:0]  rx_shift_r, rx_shift_nxt_s;
  logic        byte_valid_r, byte_valid_nxt_s;
  logic [7:0]  gpio_r;

  // Reset synchronizer: asserts asynchronously, releases two clocks after i_RST rises.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // Two-stage synchronizer for the asynchronous serial input, plus one delayed copy for edge detect.
  always_ff @(posedge i_CLK or negedge rst_n_s) begin
    if (!rst_n_s) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= i_UART_TXD;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge i_CLK or negedge rst_n_s) begin
    if (!rst_n_s) begin
      rx_state_r   <= RX_IDLE;
      rx_cnt_r     <= 16'd0;
      rx_bit_r     <= 3'd0;
      rx_shift_r   <= 8'd0;
      byte_valid_r <= 1'b0;
    end else begin
      rx_state_r   <= rx_state_nxt_s;
      rx_cnt_r     <= rx_cnt_nxt_s;
      rx_bit_r     <= rx_bit_nxt_s;
      rx_shift_r   <= rx_shift_nxt_s;
      byte_valid_r <= byte_valid_nxt_s;
    end
  end

  // Receiver next-state logic; the start bit is re-checked at mid-bit to reject glitches.
  always_comb begin
    rx_state_nxt_s   = rx_state_r;
    rx_cnt_nxt_s     = rx_cnt_r + 16'd1;
    rx_bit_nxt_s     = rx_bit_r;
    rx_shift_nxt_s   = rx_shift_r;
    byte_valid_nxt_s = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_nxt_s = 16'd0;
        if (rx_prev_r && !rx_sync_r) begin
          rx_state_nxt_s = RX_START;
        end else begin
          rx_state_nxt_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_r == HALF_M1) begin
          rx_cnt_nxt_s = 16'd0;
          if (!rx_sync_r) begin
            rx_state_nxt_s = RX_DATA;
            rx_bit_nxt_s   = 3'd0;
          end else begin
            rx_state_nxt_s = RX_IDLE;
          end
        end else begin
          rx_state_nxt_s = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == BIT_M1) begin
          rx_cnt_nxt_s   = 16'd0;
          rx_shift_nxt_s = {rx_sync_r, rx_shift_r[7:1]};
          if (rx_bit_r == 3'd7) begin
            rx_state_nxt_s = RX_STOP;
          end else begin
            rx_bit_nxt_s = rx_bit_r + 3'd1;
          end
        end else begin
          rx_state_nxt_s = RX_DATA;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == BIT_M1) begin
          rx_cnt_nxt_s = 16'd0;
          if (rx_sync_r) begin
            byte_valid_nxt_s = 1'b1;
            rx_state_nxt_s   = RX_IDLE;
          end else begin
            rx_state_nxt_s = RX_WAIT_IDLE;
          end
        end else begin
          rx_state_nxt_s = RX_STOP;
        end
      end
      RX_WAIT_IDLE: begin
        rx_cnt_nxt_s = 16'd0;
        if (rx_sync_r) begin
          rx_state_nxt_s = RX_IDLE;
        end else begin
          rx_state_nxt_s = RX_WAIT_IDLE;
        end
      end
      default: begin
        rx_state_nxt_s = RX_IDLE;
        rx_cnt_nxt_s   = 16'd0;
      end
    endcase
  end

  // GPIO register, written only by a completed, correctly framed byte.
  always_ff @(posedge i_CLK or negedge rst_n_s) begin
    if (!rst_n_s) begin
      gpio_r <= 8'd0;
    end else if (byte_valid_r) begin
      gpio_r <= rx_shift_r;
    end
  end

  assign o_GPIO_0 = gpio_r[0];
  assign o_GPIO_1 = gpio_r[1];
  assign o_GPIO_2 = gpio_r[2];
  assign o_GPIO_3 = gpio_r[3];
  assign o_GPIO_4 = gpio_r[4];
  assign o_GPIO_5 = gpio_r[5];
  assign o_GPIO_6 = gpio_r[6];
  assign o_GPIO_7 = gpio_r[7];

`ifdef UART_ECHO_EN
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  tx_state_t   tx_state_r, tx_state_nxt_s;
  logic [15:0] tx_cnt_r, tx_cnt_nxt_s;
  logic [2:0]  tx_bit_r, tx_bit_nxt_s;
  logic [7:0]  tx_hold_r, tx_hold_nxt_s;
  logic        tx_out_r, tx_out_nxt_s;
  logic        echo_req_r;

  // Echo request follows the GPIO load by one cycle so the start bit trails the GPIO update.
  always_ff @(posedge i_CLK or negedge rst_n_s) begin
    if (!rst_n_s) begin
      echo_req_r <= 1'b0;
    end else begin
      echo_req_r <= byte_valid_r;
    end
  end

  // Transmitter state and datapath registers.
  always_ff @(posedge i_CLK or negedge rst_n_s) begin
    if (!rst_n_s) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= 16'd0;
      tx_bit_r   <= 3'd0;
      tx_hold_r  <= 8'd0;
      tx_out_r   <= 1'b1;
    end else begin
      tx_state_r <= tx_state_nxt_s;
      tx_cnt_r   <= tx_cnt_nxt_s;
      tx_bit_r   <= tx_bit_nxt_s;
      tx_hold_r  <= tx_hold_nxt_s;
      tx_out_r   <= tx_out_nxt_s;
    end
  end

  // Transmitter next-state logic; a request arriving while busy is simply not accepted.
  always_comb begin
    tx_state_nxt_s = tx_state_r;
    tx_cnt_nxt_s   = tx_cnt_r + 16'd1;
    tx_bit_nxt_s   = tx_bit_r;
    tx_hold_nxt_s  = tx_hold_r;
    tx_out_nxt_s   = tx_out_r;
    case (tx_state_r)
      TX_IDLE: begin
        tx_cnt_nxt_s = 16'd0;
        if (echo_req_r) begin
          tx_state_nxt_s = TX_START;
          tx_hold_nxt_s  = gpio_r;
          tx_out_nxt_s   = 1'b0;
        end else begin
          tx_out_nxt_s = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt_r == BIT_M1) begin
          tx_state_nxt_s = TX_DATA;
          tx_cnt_nxt_s   = 16'd0;
          tx_bit_nxt_s   = 3'd0;
          tx_out_nxt_s   = tx_hold_r[0];
        end else begin
          tx_state_nxt_s = TX_START;
        end
      end
      TX_DATA: begin
        if (tx_cnt_r == BIT_M1) begin
          tx_cnt_nxt_s = 16'd0;
          if (tx_bit_r == 3'd7) begin
            tx_state_nxt_s = TX_STOP;
            tx_out_nxt_s   = 1'b1;
          end else begin
            tx_bit_nxt_s  = tx_bit_r + 3'd1;
            tx_hold_nxt_s = {1'b0, tx_hold_r[7:1]};
            tx_out_nxt_s  = tx_hold_r[1];
          end
        end else begin
          tx_state_nxt_s = TX_DATA;
        end
      end
      TX_STOP: begin
        if (tx_cnt_r == BIT_M1) begin
          tx_state_nxt_s = TX_IDLE;
          tx_cnt_nxt_s   = 16'd0;
          tx_out_nxt_s   = 1'b1;
        end else begin
          tx_state_nxt_s = TX_STOP;
        end
      end
      default: begin
        tx_state_nxt_s = TX_IDLE;
        tx_cnt_nxt_s   = 16'd0;
        tx_out_nxt_s   = 1'b1;
      end
    endcase
  end

  assign o_UART_RXD = tx_out_r;
`else
  assign o_UART_RXD = 1'b1;
`endif

endmodule

// File: tb/tb_pygmy_uart_gpio_system.sv
// Directed self-checking bench for pygmy_uart_gpio_system with a shortened bit period.
module tb_pygmy_uart_gpio_system;

  localparam int CPB = 100;

  logic clk;
  logic rst;
  logic txd;
  logic rxd;
  logic g0, g1, g2, g3, g4, g5, g6, g7;
  logic [7:0] gpio;
  int errors = 0;
  int checks = 0;

  assign gpio = {g7, g6, g5, g4, g3, g2, g1, g0};

  pygmy_uart_gpio_system #(.CLKS_PER_BIT(CPB)) dut (
    .i_CLK(clk), .i_RST(rst), .i_UART_TXD(txd), .o_UART_RXD(rxd),
    .o_GPIO_0(g0), .o_GPIO_1(g1), .o_GPIO_2(g2), .o_GPIO_3(g3),
    .o_GPIO_4(g4), .o_GPIO_5(g5), .o_GPIO_6(g6), .o_GPIO_7(g7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int period);
    txd = v;
    repeat (period) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stopv, input int period);
    drive_bit(1'b0, period);
    for (int i = 0; i < 8; i++) drive_bit(d[i], period);
    drive_bit(stopv, period);
    txd = 1'b1;
  endtask

  initial begin
    logic found;
    logic [9:0] frame;
    int low_cnt;

    rst = 1'b0;
    txd = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_gpio", {24'd0, gpio}, 32'h00);
    check("reset_rxd", {31'd0, rxd}, 32'h1);

    rst = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (rxd !== 1'b1) low_cnt++;
    end
    check("idle_gpio", {24'd0, gpio}, 32'h00);
    check("idle_rxd_low_cycles", low_cnt, 0);

    // 0x61 at a 2% slow host rate, watching for the GPIO update inside the stop bit
    drive_bit(1'b0, CPB + 2);
    for (int i = 0; i < 8; i++) drive_bit(1'(8'h61 >> i), CPB + 2);
    txd = 1'b1;
    @(negedge clk);
    check("gpio_before_stop", {24'd0, gpio}, 32'h00);
    found = 1'b0;
    for (int i = 0; i < 2 * CPB && !found; i++) begin
      @(negedge clk);
      if (gpio == 8'h61) found = 1'b1;
    end
    check("rx_0x61_seen", {31'd0, found}, 32'h1);
    check("rx_0x61_value", {24'd0, gpio}, 32'h61);
    check("rxd_high_at_gpio_update", {31'd0, rxd}, 32'h1);

`ifdef UART_ECHO_EN
    frame = {1'b1, 8'h61, 1'b0};
    @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      if (b != 0) @(negedge clk);
      check($sformatf("echo_bit%0d_first", b), {31'd0, rxd}, {31'd0, frame[b]});
      repeat (CPB - 1) @(negedge clk);
      check($sformatf("echo_bit%0d_last", b), {31'd0, rxd}, {31'd0, frame[b]});
    end
    @(negedge clk);
    check("echo_idle_after", {31'd0, rxd}, 32'h1);
`else
    frame = 10'h3ff;
    low_cnt = 0;
    for (int i = 0; i < 11 * CPB; i++) begin
      @(negedge clk);
      if (rxd !== frame[0]) low_cnt++;
    end
    check("no_echo_low_cycles", low_cnt, 0);
`endif
    repeat (500) @(negedge clk);
    check("gpio_holds_0x61", {24'd0, gpio}, 32'h61);

    // framing error leaves GPIO untouched
    send_byte(8'hA5, 1'b0, CPB);
    repeat (3 * CPB) @(negedge clk);
    check("framing_err_keeps", {24'd0, gpio}, 32'h61);

    send_byte(8'h3C, 1'b1, CPB - 2);
    repeat (10) @(negedge clk);
    check("rx_0x3c", {24'd0, gpio}, 32'h3C);

    // short glitch shorter than half a bit
    txd = 1'b0;
    repeat (30) @(negedge clk);
    txd = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_ignored", {24'd0, gpio}, 32'h3C);
    send_byte(8'hFF, 1'b1, CPB);
    repeat (10) @(negedge clk);
    check("rx_0xff", {24'd0, gpio}, 32'hFF);

    // reset during data bit 4 of 0x55
    repeat (200) @(negedge clk);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h55 >> i), CPB);
    txd = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midframe_reset_gpio", {24'd0, gpio}, 32'h00);
    check("midframe_reset_rxd", {31'd0, rxd}, 32'h1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("no_partial_byte", {24'd0, gpio}, 32'h00);
    send_byte(8'h0F, 1'b1, CPB + 1);
    repeat (10) @(negedge clk);
    check("rx_0x0f", {24'd0, gpio}, 32'h0F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
